// File: rtl/button_debounce.sv
// button_debounce: multi-channel pushbutton conditioner.
// Each raw, bouncy, asynchronous button goes through a 2-flop synchronizer.
// A per-channel debounce FSM then turns it into a clean registered level,
// one-cycle press and release pulses, and an auto-repeating step pulse.
//
// Handshake: none. The block is free-running. Every output pulse is high for
// exactly one clk cycle, and there is no backpressure.
//
// reset_n asserts asynchronously. Its deassertion is expected to be aligned
// to clk by the board reset source, so there is no local reset synchronizer.
// As a result, the press latency after reset matches the normal latency.
module button_debounce #(
    parameter int            N               = 5,
    parameter int            DEBOUNCE_CYCLES = 1000000,
    parameter int            REPEAT_DELAY    = 50000000,
    parameter int            REPEAT_PERIOD   = 10000000,
    parameter logic [N-1:0]  REPEAT_MASK     = 5'b01111
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     btn_in,
    output logic [N-1:0]     btn_level,
    output logic [N-1:0]     btn_press,
    output logic [N-1:0]     btn_release,
    output logic [N-1:0]     btn_step,
    // FSM state of every channel, 2 bits per channel (channel i at [2i+1:2i])
    output logic [2*N-1:0]   fsm_state
);

    // Debounce counter width. It holds values up to DEBOUNCE_CYCLES-1.
    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Repeat counter width. It covers the longer of the two repeat intervals.
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    state_t        state [N];
    logic [DW-1:0] dcnt  [N];
    logic [RW-1:0] rcnt  [N];
    logic [N-1:0]  first;

    // Two-flop synchronizer. The FSM below only ever looks at sync2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce and auto-repeat FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_step    <= '0;
            first       <= '0;
            for (int i = 0; i < N; i++) begin
                state[i] <= RELEASED;
                dcnt[i]  <= '0;
                rcnt[i]  <= '0;
            end
        end else begin
            // Pulses default low, so each one lasts a single cycle.
            btn_press   <= '0;
            btn_release <= '0;
            btn_step    <= '0;
            for (int i = 0; i < N; i++) begin
                case (state[i])
                    RELEASED: begin
                        if (sync2[i]) begin
                            state[i] <= PRESS_PEND;
                            dcnt[i]  <= '0;
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync2[i]) begin
                            // A bounce: drop back silently.
                            state[i] <= RELEASED;
                        end else if (dcnt[i] == D_LAST) begin
                            state[i]     <= HELD;
                            btn_press[i] <= 1'b1;
                            btn_step[i]  <= 1'b1;
                            btn_level[i] <= 1'b1;
                            rcnt[i]      <= '0;
                            first[i]     <= 1'b1;
                        end else begin
                            dcnt[i] <= dcnt[i] + DW'(1);
                        end
                    end
                    HELD: begin
                        if (!sync2[i]) begin
                            // rcnt is deliberately left untouched while the release is pending.
                            state[i] <= RELEASE_PEND;
                            dcnt[i]  <= '0;
                        end else if (REPEAT_MASK[i]) begin
                            if (first[i] && (rcnt[i] == RD_LAST)) begin
                                btn_step[i] <= 1'b1;
                                rcnt[i]     <= '0;
                                first[i]    <= 1'b0;
                            end else if (!first[i] && (rcnt[i] == RP_LAST)) begin
                                btn_step[i] <= 1'b1;
                                rcnt[i]     <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RW'(1);
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (sync2[i]) begin
                            // A release glitch: resume the hold where it paused.
                            state[i] <= HELD;
                        end else if (dcnt[i] == D_LAST) begin
                            state[i]       <= RELEASED;
                            btn_release[i] <= 1'b1;
                            btn_level[i]   <= 1'b0;
                        end else begin
                            dcnt[i] <= dcnt[i] + DW'(1);
                        end
                    end
                    default: state[i] <= RELEASED;
                endcase
            end
        end
    end

    // Flatten the per-channel states for observation.
    always_comb begin
        fsm_state = '0;
        for (int i = 0; i < N; i++) begin
            fsm_state[2*i +: 2] = state[i];
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed scenarios plus random button activity.
// The checks compare the DUT against a run-length reference model.
// The model's debounce rule: a button level changes once the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES+1 consecutive samples.
// The model's repeat rule: steps occur when the accumulated undisturbed hold
// time reaches REPEAT_DELAY + k*REPEAT_PERIOD.
module tb_button_debounce;

    localparam int N  = 5;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam logic [N-1:0] MASK = 5'b01111;
    localparam int W  = 6 * N;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   btn_in;
    logic [N-1:0]   btn_level;
    logic [N-1:0]   btn_press;
    logic [N-1:0]   btn_release;
    logic [N-1:0]   btn_step;
    logic [2*N-1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    button_debounce #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_step    (btn_step),
        .fsm_state   (fsm_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: 2-sample input delay, then run-length debounce and hold-time repeat.
    logic [N-1:0]   m_d1, m_d2, m_level, m_s;
    logic [N-1:0]   m_press, m_rel, m_step;
    logic [2*N-1:0] m_st;
    int             m_run   [N];
    int             m_ticks [N];
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   exp_v;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d1    = '0;
            m_d2    = '0;
            m_level = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i]   = 0;
                m_ticks[i] = 0;
            end
            exp_q.delete();
        end else begin
            m_s     = m_d2;
            m_press = '0;
            m_rel   = '0;
            m_step  = '0;
            m_st    = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s[i] == m_level[i]) begin
                    // Hold time accrues only while no release is pending.
                    if (m_level[i] && m_run[i] == 0 && MASK[i]) begin
                        m_ticks[i]++;
                        if (m_ticks[i] >= RD && ((m_ticks[i] - RD) % RP) == 0)
                            m_step[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DC + 1) begin
                        m_level[i] = m_s[i];
                        m_run[i]   = 0;
                        if (m_s[i]) begin
                            m_press[i] = 1'b1;
                            m_step[i]  = 1'b1;
                            m_ticks[i] = 0;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end
                m_st[2*i +: 2] = {m_level[i], (m_run[i] != 0)};
            end
            exp_q.push_back({m_level, m_press, m_rel, m_step, m_st});
            m_d2 = m_d1;
            m_d1 = btn_in;
        end
    end

    // Scoreboard: one expected vector per clock, compared on the falling edge.
    always @(negedge clk) begin
        if (reset_n && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_eq("sb_level",   32'(btn_level),   32'(exp_v[6*N-1:5*N]));
            check_eq("sb_press",   32'(btn_press),   32'(exp_v[5*N-1:4*N]));
            check_eq("sb_release", 32'(btn_release), 32'(exp_v[4*N-1:3*N]));
            check_eq("sb_step",    32'(btn_step),    32'(exp_v[3*N-1:2*N]));
            check_eq("sb_state",   32'(fsm_state),   32'(exp_v[2*N-1:0]));
        end
    end

    // Per-scenario observations, in edges counted from the first driven sample.
    int press_e[$], release_e[$], step_e[$];
    int pend_e;
    int level_hi;

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Driver: channel ch is 1 for edges hi_from..hi_to, except gap_from..gap_to.
    task automatic run_pattern(input int ch, input int n, input int hi_from, input int hi_to,
                               input int gap_from, input int gap_to);
        press_e.delete();
        release_e.delete();
        step_e.delete();
        pend_e   = -1;
        level_hi = 0;
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            btn_in[ch] = (e >= hi_from && e <= hi_to && !(e >= gap_from && e <= gap_to));
            @(posedge clk);
            #1;
            if (btn_press[ch])   press_e.push_back(e);
            if (btn_release[ch]) release_e.push_back(e);
            if (btn_step[ch])    step_e.push_back(e);
            if (pend_e < 0 && fsm_state[2*ch +: 2] == 2'd1) pend_e = e;
            if (btn_level[ch])   level_hi++;
        end
    endtask

    int remain [N];

    initial begin
        reset_n = 1'b0;
        btn_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_step}), 32'(0));
        check_eq("reset_state",   32'(fsm_state), 32'(0));
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Clean press on ch0, held.
        run_pattern(0, 45, 1, 45, 0, 0);
        check_eq("ch0_pend_edge",  32'(pend_e), 32'(3));
        check_eq("ch0_press_cnt",  32'(press_e.size()), 32'(1));
        check_eq("ch0_press_edge", 32'(q_at(press_e, 0)), 32'(DC + 3));
        check_eq("ch0_step_cnt",   32'(step_e.size()), 32'(4));
        check_eq("ch0_step0",      32'(q_at(step_e, 0)), 32'(7));
        check_eq("ch0_step1",      32'(q_at(step_e, 1)), 32'(7 + RD));
        check_eq("ch0_step2",      32'(q_at(step_e, 2)), 32'(7 + RD + RP));
        check_eq("ch0_step3",      32'(q_at(step_e, 3)), 32'(7 + RD + 2 * RP));
        check_eq("ch0_level_hi",   32'(level_hi), 32'(45 - 6));

        // Release ch0.
        run_pattern(0, 20, 0, 0, 0, 0);
        check_eq("ch0_rel_cnt",    32'(release_e.size()), 32'(1));
        check_eq("ch0_rel_edge",   32'(q_at(release_e, 0)), 32'(DC + 3));
        check_eq("ch0_rel_steps",  32'(step_e.size()), 32'(0));
        check_eq("ch0_rel_press",  32'(press_e.size()), 32'(0));
        check_eq("ch0_rel_level",  32'(btn_level[0]), 32'(0));

        // Bounce on ch1: 1,1,0,0,1,1 then 0.
        run_pattern(1, 20, 1, 6, 3, 4);
        check_eq("ch1_press_cnt",  32'(press_e.size()), 32'(0));
        check_eq("ch1_rel_cnt",    32'(release_e.size()), 32'(0));
        check_eq("ch1_step_cnt",   32'(step_e.size()), 32'(0));
        check_eq("ch1_level_hi",   32'(level_hi), 32'(0));

        // Release glitch on ch2: 2-cycle drop while held shifts repeats by 3.
        run_pattern(2, 40, 1, 40, 11, 12);
        check_eq("ch2_press_edge", 32'(q_at(press_e, 0)), 32'(7));
        check_eq("ch2_rel_cnt",    32'(release_e.size()), 32'(0));
        check_eq("ch2_step_cnt",   32'(step_e.size()), 32'(3));
        check_eq("ch2_step1",      32'(q_at(step_e, 1)), 32'(7 + RD + 3));
        check_eq("ch2_step2",      32'(q_at(step_e, 2)), 32'(7 + RD + 3 + RP));
        check_eq("ch2_level_hi",   32'(level_hi), 32'(40 - 6));
        run_pattern(2, 15, 0, 0, 0, 0);
        check_eq("ch2_rel_edge",   32'(q_at(release_e, 0)), 32'(7));

        // Masked ch4: held 60 cycles, a single step coincident with the press.
        run_pattern(4, 70, 1, 60, 0, 0);
        check_eq("ch4_press_cnt",  32'(press_e.size()), 32'(1));
        check_eq("ch4_step_cnt",   32'(step_e.size()), 32'(1));
        check_eq("ch4_step_edge",  32'(q_at(step_e, 0)), 32'(q_at(press_e, 0)));
        check_eq("ch4_rel_edge",   32'(q_at(release_e, 0)), 32'(60 + 7));

        // Async reset while ch3 is held, away from any clock edge.
        run_pattern(3, 15, 1, 15, 0, 0);
        check_eq("ch3_press_edge", 32'(q_at(press_e, 0)), 32'(7));
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_async_out",   32'({btn_level, btn_press, btn_release, btn_step}), 32'(0));
        check_eq("rst_async_state", 32'(fsm_state), 32'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_out", 32'({btn_level, btn_press, btn_release, btn_step}), 32'(0));
        end
        #1 reset_n = 1'b1;
        run_pattern(3, 12, 1, 12, 0, 0);
        check_eq("ch3_repress_edge", 32'(q_at(press_e, 0)), 32'(DC + 3));
        check_eq("ch3_repress_rel",  32'(release_e.size()), 32'(0));
        run_pattern(3, 12, 0, 0, 0, 0);
        check_eq("ch3_rel_edge",     32'(q_at(release_e, 0)), 32'(7));

        // Random activity on all channels, checked by the scoreboard each cycle.
        for (int i = 0; i < N; i++) remain[i] = 0;
        repeat (800) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (remain[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    remain[i] = $urandom_range(1, 30);
                end else begin
                    remain[i]--;
                end
            end
        end
        @(negedge clk);
        btn_in = '0;
        repeat (20) @(negedge clk);
        #1;
        check_eq("final_level", 32'(btn_level), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
